seg7_scan_display: RTL and testbench
====================================

# seg7_scan_display

Parametrised multiplexed 7-segment display driver for the Snake score path. It accepts a binary value through a load strobe and converts it to BCD sequentially (double-dabble, one bit per clock). The result is latched into a tear-free display register, which is time-multiplexed across `DIGITS` common-anode digits. Over the fixed 3-digit, always-converting driver it adds:
- generic width and digit count;
- leading-zero blanking;
- overflow indication;
- a busy handshake.

## Interface
Parameters:
- `DIGITS`, 3: number of digits; 1..8.
- `BIN_W`, 8: width of the binary input; 1..26.
- `REFRESH_DIV`, 131072: clock cycles per digit slot; ≥2.
- `SEG_ACTIVE_LOW`, 0: 1 inverts `seg`.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `binary`  in  BIN_W: value to display, sampled on load acceptance.
- `load`  in  1: conversion request; accepted when `busy`=0.
- `blank_lz`  in  1: 1 blanks leading zero digits; sampled live.
- `busy`  out  1: conversion in progress.
- `overflow`  out  1: last committed value ≥ 10^DIGITS.
- `seg`  out  7: segments {g,f,e,d,c,b,a}; active-high unless `SEG_ACTIVE_LOW`.
- `ca`  out  DIGITS: digit enables, active-low, one-hot-low; `ca[0]` = ones digit.

## Operation
- Conversion FSM has three states:
  - **IDLE**: on `load`=1, capture `binary` into the shift register, clear the BCD accumulator (DIGITS×4 bits) and the sticky overflow bit, set iteration counter to 0, go to CONV.
  - **CONV**: each cycle, add 3 to every BCD nibble ≥5, then shift {BCD, shift} left by 1. The MSB of the shift register enters BCD bit 0. A 1 shifted out of the top nibble sets sticky overflow. After BIN_W iterations, go to COMMIT.
  - **COMMIT**: copy BCD to the display register and sticky overflow to `overflow`, return to IDLE.
- `busy` = (state ≠ IDLE). A `load` while busy, including during COMMIT, is ignored; it is not queued.
- The display register changes only in COMMIT, so the old value stays displayed for the whole conversion.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1.
  - On its terminal count it wraps to 0 and the digit index advances.
  - The index wraps from DIGITS-1 to 0.
- Digit k content:
  - If `overflow`=1: dash (segment g only) on every digit.
  - Else if `blank_lz`=1, k>0, and nibbles k..DIGITS-1 are all zero: blank (all segments off).
  - Else: decimal glyph of nibble k.
  - Digit 0 is never blanked.
- Glyphs (gfedcba, active-high): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, dash=40, blank=00.
  - Nibble values >9 are unreachable and are treated as blank.
- `seg` and `ca` are registered from the index and display register.

## Timing
- Reset values:
  - state IDLE, `busy`=0, `overflow`=0;
  - display register 0, refresh counter 0, digit index 0;
  - `ca` all 1 (all off), `seg` all off after polarity.
  - First edge after reset release: `ca` = ~1 and `seg` = glyph "0".
- Load accepted at edge t:
  - `busy`=1 from t until edge t+BIN_W+1.
  - Iterations at edges t+1..t+BIN_W; commit at edge t+BIN_W+1.
  - `busy`=0 and new `overflow` are visible after that same edge.
  - Earliest next acceptance is at edge t+BIN_W+2.
- New digit data reaches `seg` one cycle after commit, on whichever digit is currently scanned.
- Digit slot length is exactly REFRESH_DIV cycles; full frame = DIGITS×REFRESH_DIV cycles.
- `ca` and `seg` change on the same edge; no cycle shows mixed old-digit/new-digit output.
- `rst` mid-conversion aborts the conversion: display cleared to 0, no partial commit.
- `blank_lz` changes take effect on the next registered output update.

## Test plan
- Reset, defaults: hold `rst` 2 cycles, release -> `busy`=0, `overflow`=0, `ca`=110, `seg`=3F; with REFRESH_DIV=4, `ca` sequence 110,101,011,110 every 4 cycles.
- Load 255, BIN_W=8: pulse `load` -> `busy` high for exactly 9 cycles; digits ones/tens/hundreds = 6D/6D/5B; old display unchanged until commit.
- Leading zeros: load 7 with `blank_lz`=1 -> digits = 07/00/00; load 7 with `blank_lz`=0 -> digits = 07/3F/3F; load 0 with `blank_lz`=1 -> digits = 3F/00/00.
- Overflow, DIGITS=2, BIN_W=8: load 100 -> `overflow`=1, all digits 40; then load 99 -> `overflow`=0, digits 6F/6F.
- Handshake: assert `load` with 42 while busy, and again in the COMMIT cycle -> both ignored, display shows first value; `load` held high continuously -> one conversion every BIN_W+2 cycles.
- Reset mid-conversion: load 255, assert `rst` at iteration 4 -> display 0, `busy`=0, no commit of 255; SEG_ACTIVE_LOW=1 run -> `seg` bitwise inverted for all glyphs above.

Source files
------------

// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if
//   Value/handshake bundle between a score producer and the 7-segment driver.
//   binary   : value to display, sampled when a load is accepted
//   load     : conversion request, honoured only while busy is low
//   blank_lz : 1 blanks leading zero digits (used live)
//   busy     : conversion in progress
//   overflow : last committed value did not fit in the digit count
interface seg7_scan_display_if #(
    parameter int BIN_W = 8
);
    logic [BIN_W-1:0] binary;
    logic             load;
    logic             blank_lz;
    logic             busy;
    logic             overflow;

    modport master (output binary, load, blank_lz, input  busy, overflow);
    modport slave  (input  binary, load, blank_lz, output busy, overflow);
endinterface

// File: rtl/seg7_scan_display.sv
// seg7_scan_display
//   Sequential binary-to-BCD (double-dabble, one bit per clock) feeding a
//   tear-free display register that is time-multiplexed over DIGITS
//   common-anode digits.
//   clk  : clock, rising edge
//   rst  : synchronous reset, active high
//   bus  : seg7_scan_display_if slave (binary/load/blank_lz in, busy/overflow out)
//   seg  : segments {g,f,e,d,c,b,a}, active high unless SEG_ACTIVE_LOW
//   ca   : digit enables, active low one-hot, ca[0] = ones digit

// Double-dabble correction for one BCD nibble: add 3 when >= 5.
module seg7_dabble_nibble (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module seg7_scan_display #(
    parameter int DIGITS         = 3,
    parameter int BIN_W          = 8,
    parameter int REFRESH_DIV    = 131072,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    seg7_scan_display_if.slave     bus,
    output logic [6:0]             seg,
    output logic [DIGITS-1:0]      ca
);
    localparam int BCD_W = DIGITS * 4;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int REF_W = $clog2(REFRESH_DIV);
    // XOR mask: applying it to an active-high pattern gives the pin polarity.
    localparam logic [6:0] SEG_POL = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t           state, state_nx;
    logic [BIN_W-1:0] sh_q;
    logic [BCD_W-1:0] bcd_q, bcd_adj, disp_q;
    logic             ovf_sticky, ovf_q;
    logic [CNT_W-1:0] iter_q;

    logic [REF_W-1:0] ref_q;
    logic [IDX_W-1:0] idx_q;
    logic [DIGITS-1:0] lz;
    logic [3:0]       nib;
    logic             lz_sel;
    logic [6:0]       seg_nx;

    // ---------------- conversion ----------------
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        seg7_dabble_nibble u_adj (.d(bcd_q[g*4 +: 4]), .q(bcd_adj[g*4 +: 4]));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.load) state_nx = CONV;
            CONV:    if (iter_q == CNT_W'(BIN_W - 1)) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sh_q       <= '0;
            bcd_q      <= '0;
            ovf_sticky <= 1'b0;
            iter_q     <= '0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (bus.load) begin
                    sh_q       <= bus.binary;
                    bcd_q      <= '0;
                    ovf_sticky <= 1'b0;
                    iter_q     <= '0;
                end
                CONV: begin
                    // Top bit of the corrected top nibble falls off the end:
                    // the value needs more digits than we have.
                    {bcd_q, sh_q} <= {bcd_adj[BCD_W-2:0], sh_q, 1'b0};
                    ovf_sticky    <= ovf_sticky | bcd_adj[BCD_W-1];
                    iter_q        <= iter_q + 1'b1;
                end
                COMMIT: begin
                    disp_q <= bcd_q;
                    ovf_q  <= ovf_sticky;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.overflow = ovf_q;

    // ---------------- scan ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q <= '0;
            idx_q <= '0;
        end else if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_q <= '0;
            idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            ref_q <= ref_q + 1'b1;
        end
    end

    // lz[k]: nibbles k..DIGITS-1 are all zero.
    for (genvar k = 0; k < DIGITS; k++) begin : g_lz
        assign lz[k] = ~|disp_q[BCD_W-1:k*4];
    end

    always_comb begin
        nib    = 4'd0;
        lz_sel = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib    = disp_q[k*4 +: 4];
                lz_sel = lz[k];
            end
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h00;
        endcase
    endfunction

    always_comb begin
        seg_nx = glyph(nib);
        if (ovf_q)
            seg_nx = 7'h40;
        else if (bus.blank_lz && (idx_q != '0) && lz_sel)
            seg_nx = 7'h00;
    end

    // seg and ca come from the same index in the same register stage,
    // so a digit switch never mixes old and new outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_POL;
            ca  <= '1;
        end else begin
            seg <= seg_nx ^ SEG_POL;
            ca  <= ~(DIGITS'(1) << idx_q);
        end
    end
endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;
    logic clk = 1'b0;
    logic rst;
    logic [7:0] bin;
    logic ld, blz;

    always #5 clk = ~clk;

    seg7_scan_display_if #(.BIN_W(8)) if0 ();
    seg7_scan_display_if #(.BIN_W(8)) if1 ();
    seg7_scan_display_if #(.BIN_W(8)) if2 ();
    assign if0.binary = bin; assign if0.load = ld; assign if0.blank_lz = blz;
    assign if1.binary = bin; assign if1.load = ld; assign if1.blank_lz = blz;
    assign if2.binary = bin; assign if2.load = ld; assign if2.blank_lz = blz;

    logic [6:0] seg0, seg1, seg2;
    logic [2:0] ca0, ca2;
    logic [1:0] ca1;

    // u0: reference 3-digit, u1: 2-digit for overflow, u2: active-low segments
    seg7_scan_display #(.DIGITS(3), .BIN_W(8), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0))
        u0 (.clk(clk), .rst(rst), .bus(if0.slave), .seg(seg0), .ca(ca0));
    seg7_scan_display #(.DIGITS(2), .BIN_W(8), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0))
        u1 (.clk(clk), .rst(rst), .bus(if1.slave), .seg(seg1), .ca(ca1));
    seg7_scan_display #(.DIGITS(3), .BIN_W(8), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1))
        u2 (.clk(clk), .rst(rst), .bus(if2.slave), .seg(seg2), .ca(ca2));

    int ncmp = 0;
    int nerr = 0;
    logic [6:0] d0 [3];
    logic [6:0] d1 [2];
    logic [6:0] d2 [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (if0.busy !== 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", {31'd0, if0.busy}, 32'd0);
    endtask

    // Record the glyph shown on every digit over a bit more than one frame.
    task automatic capture();
        for (int i = 0; i < 3; i++) begin d0[i] = 'x; d2[i] = 'x; end
        for (int i = 0; i < 2; i++) d1[i] = 'x;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            case (ca0) 3'b110: d0[0] = seg0; 3'b101: d0[1] = seg0; 3'b011: d0[2] = seg0; default: ; endcase
            case (ca2) 3'b110: d2[0] = seg2; 3'b101: d2[1] = seg2; 3'b011: d2[2] = seg2; default: ; endcase
            case (ca1) 2'b10:  d1[0] = seg1; 2'b01:  d1[1] = seg1; default: ; endcase
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        bin = v; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        wait_idle();
        capture();
    endtask

    task automatic chk3(input string tag, input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
        chk({tag, "_u0_d0"}, {25'd0, d0[0]}, {25'd0, e0});
        chk({tag, "_u0_d1"}, {25'd0, d0[1]}, {25'd0, e1});
        chk({tag, "_u0_d2"}, {25'd0, d0[2]}, {25'd0, e2});
        chk({tag, "_u2_d0"}, {25'd0, d2[0]}, {25'd0, e0 ^ 7'h7F});
        chk({tag, "_u2_d1"}, {25'd0, d2[1]}, {25'd0, e1 ^ 7'h7F});
        chk({tag, "_u2_d2"}, {25'd0, d2[2]}, {25'd0, e2 ^ 7'h7F});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, r0, r1, prev;
        rst = 1'b1; ld = 1'b0; bin = '0; blz = 1'b0;

        // reset
        repeat (2) @(negedge clk);
        chk("rst_ca", {29'd0, ca0}, 32'h7);
        chk("rst_seg", {25'd0, seg0}, 32'h00);
        chk("rst_seg_al", {25'd0, seg2}, 32'h7F);
        rst = 1'b0;
        @(negedge clk);                       // after edge 1
        chk("def_busy", {31'd0, if0.busy}, 32'd0);
        chk("def_ovf", {31'd0, if0.overflow}, 32'd0);
        chk("def_ca", {29'd0, ca0}, 32'h6);
        chk("def_seg", {25'd0, seg0}, 32'h3F);
        chk("def_seg_al", {25'd0, seg2}, 32'h40);
        chk("def_ca_2dig", {30'd0, ca1}, 32'h2);
        repeat (3) @(negedge clk);            // edge 4: slot still digit 0
        chk("scan_e4", {29'd0, ca0}, 32'h6);
        @(negedge clk);
        chk("scan_e5", {29'd0, ca0}, 32'h5);
        repeat (4) @(negedge clk);
        chk("scan_e9", {29'd0, ca0}, 32'h3);
        repeat (4) @(negedge clk);
        chk("scan_e13", {29'd0, ca0}, 32'h6);

        // load 255: busy for 9 cycles, old display kept meanwhile
        @(negedge clk);
        bin = 8'd255; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        chk("old_disp_seg", {25'd0, seg0}, 32'h3F);
        nb = 0;
        while (if0.busy === 1'b1 && nb < 30) begin
            @(negedge clk);
            nb++;
        end
        chk("busy_len", nb, 9);
        capture();
        chk3("v255", 7'h6D, 7'h6D, 7'h5B);
        chk("v255_u1_ovf", {31'd0, if1.overflow}, 32'd1);
        chk("v255_u1_d0", {25'd0, d1[0]}, 32'h40);
        chk("v255_u1_d1", {25'd0, d1[1]}, 32'h40);

        // leading zeros
        blz = 1'b1;
        do_load(8'd7);
        chk3("v7_blz", 7'h07, 7'h00, 7'h00);
        chk("v7_u1_d1", {25'd0, d1[1]}, 32'h00);
        blz = 1'b0;
        do_load(8'd7);
        chk3("v7_noblz", 7'h07, 7'h3F, 7'h3F);
        blz = 1'b1;
        do_load(8'd0);
        chk3("v0_blz", 7'h3F, 7'h00, 7'h00);
        blz = 1'b0;

        // overflow on 2-digit instance
        do_load(8'd100);
        chk("v100_u1_ovf", {31'd0, if1.overflow}, 32'd1);
        chk("v100_u1_d0", {25'd0, d1[0]}, 32'h40);
        chk("v100_u1_d1", {25'd0, d1[1]}, 32'h40);
        chk("v100_u0_ovf", {31'd0, if0.overflow}, 32'd0);
        chk3("v100", 7'h3F, 7'h3F, 7'h06);
        do_load(8'd99);
        chk("v99_u1_ovf", {31'd0, if1.overflow}, 32'd0);
        chk("v99_u1_d0", {25'd0, d1[0]}, 32'h6F);
        chk("v99_u1_d1", {25'd0, d1[1]}, 32'h6F);

        // loads while busy and in COMMIT are dropped
        @(negedge clk);
        bin = 8'd123; ld = 1'b1;
        @(negedge clk);                       // N0
        ld = 1'b0;
        repeat (3) @(negedge clk);            // N3
        bin = 8'd42; ld = 1'b1;
        @(negedge clk);                       // N4
        ld = 1'b0;
        chk("hs_busy_mid", {31'd0, if0.busy}, 32'd1);
        repeat (4) @(negedge clk);            // N8: COMMIT cycle
        ld = 1'b1;
        @(negedge clk);                       // N9
        ld = 1'b0;
        chk("hs_commit_idle", {31'd0, if0.busy}, 32'd0);
        @(negedge clk);
        chk("hs_not_queued", {31'd0, if0.busy}, 32'd0);
        capture();
        chk3("v123", 7'h4F, 7'h5B, 7'h06);

        // load held high: one conversion every 10 cycles
        @(negedge clk);
        bin = 8'd5; ld = 1'b1;
        r0 = -1; r1 = -1; prev = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if0.busy === 1'b1 && prev == 0) begin
                if (r0 < 0) r0 = i; else if (r1 < 0) r1 = i;
            end
            prev = (if0.busy === 1'b1) ? 1 : 0;
        end
        ld = 1'b0;
        chk("held_period", r1 - r0, 10);
        wait_idle();

        // reset at iteration 4 of a 255 conversion
        @(negedge clk);
        bin = 8'd255; ld = 1'b1;
        @(negedge clk);                       // N0
        ld = 1'b0;
        repeat (3) @(negedge clk);            // N3
        rst = 1'b1;
        @(negedge clk);                       // N4: reset applied at iteration 4
        rst = 1'b0;
        chk("mrst_busy", {31'd0, if0.busy}, 32'd0);
        chk("mrst_ca", {29'd0, ca0}, 32'h7);
        chk("mrst_seg_al", {25'd0, seg2}, 32'h7F);
        @(negedge clk);
        chk("mrst_ca_first", {29'd0, ca0}, 32'h6);
        chk("mrst_seg_first", {25'd0, seg0}, 32'h3F);
        repeat (12) @(negedge clk);
        chk("mrst_busy_late", {31'd0, if0.busy}, 32'd0);
        capture();
        chk3("mrst_disp", 7'h3F, 7'h3F, 7'h3F);
        chk("mrst_ovf", {31'd0, if1.overflow}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
